logic_reduce_unit: RTL and testbench

LOGIC_REDUCE_UNIT -- requirements
Module: logic_reduce_unit

---
 rtl/logic_reduce_unit.sv | 123 ++++++++++++
 tb/tb_logic_reduce_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_reduce_unit.sv
// Bitwise AND/OR/XOR/NAND reduction over a valid/ready burst of words.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_data/in_last/in_op
// (00 AND, 01 OR, 10 XOR, 11 NAND), out_valid/out_ready/out_data and, with
// LOGIC_REDUCE_COUNT_EN defined, out_count (saturating beat count per burst).
module logic_reduce_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOGIC_REDUCE_COUNT_EN
  output logic [CNT_W-1:0] out_count,
`endif
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             accept;
  logic             hold;

`ifdef LOGIC_REDUCE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign in_ready = !rst && (state_q != HOLD);
  assign accept   = in_valid && in_ready;
  assign hold     = !rst && (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
`ifdef LOGIC_REDUCE_COUNT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = in_op;
          acc_d   = in_data;
`ifdef LOGIC_REDUCE_COUNT_EN
          cnt_d   = CNT_W'(1);
`endif
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          // NAND accumulates as AND; the invert happens once at the output.
          case (op_q)
            OP_OR:   acc_d = acc_q | in_data;
            OP_XOR:  acc_d = acc_q ^ in_data;
            default: acc_d = acc_q & in_data;
          endcase
`ifdef LOGIC_REDUCE_COUNT_EN
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
          if (in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      acc_q   <= '0;
`ifdef LOGIC_REDUCE_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
`ifdef LOGIC_REDUCE_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    out_valid = hold;
    out_data  = '0;
    if (hold) begin
      out_data = (op_q == OP_NAND) ? ~acc_q : acc_q;
    end
  end

`ifdef LOGIC_REDUCE_COUNT_EN
  assign out_count = hold ? cnt_q : '0;
`endif

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Randomized and directed bench for logic_reduce_unit.
// Expected results come from a burst-level reduction model.
module tb_logic_reduce_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

`ifdef LOGIC_REDUCE_COUNT_EN
  logic [7:0] out_count;
  logic       in_ready2;
  logic       out_valid2;
  logic [7:0] out_data2;
  logic [1:0] out_count2;

  logic_reduce_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_data(out_data)
  );

  logic_reduce_unit #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .in_op(in_op),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_count(out_count2), .out_data(out_data2)
  );
`else
  logic_reduce_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );
`endif

  function automatic logic [7:0] model(input logic [1:0] op,
                                       input logic [7:0] d[$]);
    logic [7:0] r;
    r = d[0];
    for (int i = 1; i < d.size(); i++) begin
      if (op == 2'b01)      r = r | d[i];
      else if (op == 2'b10) r = r ^ d[i];
      else                  r = r & d[i];
    end
    if (op == 2'b11) r = ~r;
    return r;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
    in_op    = 2'($urandom);
  endtask

  // Entered and left at a negedge; returns one cycle after the last beat.
  task automatic drive_burst(input logic [1:0] op, input logic [7:0] d[$],
                             input int gap);
    for (int i = 0; i < d.size(); i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      in_last  = (i == d.size() - 1);
      in_op    = (i == 0) ? op : 2'($urandom);
      @(negedge clk);
      idle_inputs();
      if (i != d.size() - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h want 0 0 00",
               in_ready, out_valid, out_data);
    end else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end else passed++;
    @(negedge clk);
  endtask

  task automatic test_and_burst();
    logic [7:0] d[$] = '{8'hF0, 8'h3C, 8'hFF};
    drive_burst(2'b00, d, 0);
    total++;
    if (out_valid !== 1'b1 || out_data !== model(2'b00, d) ||
        out_data !== 8'h30) begin
      $display("FAIL and_burst: valid=%b data=%h want 1 30", out_valid, out_data);
    end else passed++;
`ifdef LOGIC_REDUCE_COUNT_EN
    total++;
    if (out_count !== 8'd3) begin
      $display("FAIL and_count: got %0d want 3", out_count);
    end else passed++;
`endif
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      $display("FAIL and_return_idle: valid=%b data=%h ready=%b want 0 00 1",
               out_valid, out_data, in_ready);
    end else passed++;
  endtask

  task automatic test_nand_single();
    logic [7:0] d[$] = '{8'hA5};
    drive_burst(2'b11, d, 0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      $display("FAIL nand_single: valid=%b data=%h want 1 5a", out_valid, out_data);
    end else passed++;
`ifdef LOGIC_REDUCE_COUNT_EN
    total++;
    if (out_count !== 8'd1) begin
      $display("FAIL nand_count: got %0d want 1", out_count);
    end else passed++;
`endif
    @(negedge clk);
  endtask

  task automatic test_xor_backpressure();
    logic [7:0] d[$] = '{8'h0F, 8'hF0};
    out_ready = 1'b0;
    drive_burst(2'b10, d, 2);
    for (int c = 0; c < 3; c++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'hFF || in_ready !== 1'b0) begin
        $display("FAIL xor_hold_%0d: valid=%b data=%h ready=%b want 1 ff 0",
                 c, out_valid, out_data, in_ready);
      end else passed++;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'b1;
      in_op    = 2'b00;
      @(negedge clk);
    end
    idle_inputs();
    out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
      $display("FAIL xor_held_result: valid=%b data=%h want 1 ff",
               out_valid, out_data);
    end else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL xor_after_handshake: valid=%b ready=%b want 0 1",
               out_valid, in_ready);
    end else passed++;
  endtask

  task automatic test_op_change();
    logic [7:0] d[$] = '{8'h01, 8'h02};
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0; in_op = 2'b01;
    @(negedge clk);
    in_data = 8'h02; in_last = 1'b1; in_op = 2'b00;
    @(negedge clk);
    idle_inputs();
    total++;
    if (out_valid !== 1'b1 || out_data !== model(2'b01, d)) begin
      $display("FAIL op_change: valid=%b data=%h want 1 03", out_valid, out_data);
    end else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d[$] = '{8'h80};
    bit seen = 0;
    in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0; in_op = 2'b01;
    @(negedge clk);
    in_data = 8'h22;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (out_valid) seen = 1;
      @(negedge clk);
    end
    total++;
    if (seen) begin
      $display("FAIL reset_mid_no_output: got out_valid 1 want 0");
    end else passed++;
    drive_burst(2'b01, d, 0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h80) begin
      $display("FAIL reset_mid_next: valid=%b data=%h want 1 80",
               out_valid, out_data);
    end else passed++;
`ifdef LOGIC_REDUCE_COUNT_EN
    total++;
    if (out_count !== 8'd1) begin
      $display("FAIL reset_mid_count: got %0d want 1", out_count);
    end else passed++;
`endif
    @(negedge clk);
  endtask

`ifdef LOGIC_REDUCE_COUNT_EN
  task automatic test_saturation();
    logic [7:0] d[$];
    for (int i = 0; i < 5; i++) d.push_back(8'(1 << i));
    drive_burst(2'b01, d, 0);
    total++;
    if (out_count2 !== 2'd3 || out_count !== 8'd5 || out_data2 !== 8'h1F) begin
      $display("FAIL count_saturation: cnt2=%0d cnt=%0d data2=%h want 3 5 1f",
               out_count2, out_count, out_data2);
    end else passed++;
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    for (int b = 0; b < 25; b++) begin
      logic [7:0] d[$];
      logic [1:0] op;
      int n, gap, stall;
      logic [7:0] exp;
      op    = 2'($urandom);
      n     = $urandom_range(1, 6);
      gap   = $urandom_range(0, 2);
      stall = $urandom_range(0, 3);
      d = {};
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      exp = model(op, d);
      out_ready = (stall == 0);
      drive_burst(op, d, gap);
      for (int c = 0; c <= stall; c++) begin
        if (c == stall) out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
          $display("FAIL random_%0d_%0d: valid=%b data=%h want 1 %h",
                   b, c, out_valid, out_data, exp);
        end else passed++;
`ifdef LOGIC_REDUCE_COUNT_EN
        total++;
        if (out_count !== 8'(n)) begin
          $display("FAIL random_count_%0d: got %0d want %0d", b, out_count, n);
        end else passed++;
`endif
        @(negedge clk);
      end
      total++;
      if (out_valid !== 1'b0) begin
        $display("FAIL random_idle_%0d: valid=%b want 0", b, out_valid);
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_and_burst();
    test_nand_single();
    test_xor_backpressure();
    test_op_change();
    test_reset_mid();
`ifdef LOGIC_REDUCE_COUNT_EN
    test_saturation();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
